// File: rtl/escalonador_pkg.sv
// rtl/escalonador_pkg.sv - shared FSM encoding, default sizes and round-robin search
package escalonador_pkg;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    LIGADO = 2'd1,
    PAUSA  = 2'd2
  } estado_t;

  localparam int N_CANAIS_DEF = 4;
  localparam int LARG_DEF     = 5;
  localparam int N_MAX        = 8;
  localparam int PTR_W        = 3;

  // Returns {found, index} of the first set bit strictly after ptr, wrapping at n.
  // Iterating from the far end lets the nearest candidate overwrite the others.
  function automatic logic [PTR_W:0] rr_busca(input logic [N_MAX-1:0] pend,
                                              input logic [PTR_W-1:0] ptr,
                                              input int               n);
    logic [PTR_W:0]   r;
    logic [PTR_W-1:0] idx;
    r = '0;
    for (int k = N_MAX; k >= 1; k--) begin
      if (k <= n) begin
        idx = PTR_W'((int'(ptr) + k) % n);
        if (pend[idx]) r = {1'b1, idx};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/gerador_tick.sv
// rtl/gerador_tick.sv - tick prescaler, one-clk pulse every TICK_DIV cycles while enabled
module gerador_tick #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic habilita,
  output logic tick
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [DW-1:0] r_div;
  logic          r_tick;

  // Count while enabled; the pulse is registered on the wrap so it is glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else if (!habilita) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else if (r_div == DW'(TICK_DIV - 1)) begin
      r_div  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_div  <= r_div + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/escalonador_timer.sv
// rtl/escalonador_timer.sv - round-robin shared-slot timer scheduler; optional GUARD_TIME_EN dead-time
module escalonador_timer
  import escalonador_pkg::*;
#(
  parameter int N_CANAIS = N_CANAIS_DEF,
  parameter int LARG     = LARG_DEF,
  parameter int TICK_DIV = 1000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       habilita,
  input  logic [N_CANAIS*LARG-1:0]   intervalo,
  input  logic [N_CANAIS*LARG-1:0]   tempo_ligado,
  output logic [N_CANAIS-1:0]        saida,
  output logic                       ocupado,
  output logic [N_CANAIS-1:0]        pendentes,
  output logic [N_CANAIS-1:0]        estouro
);

  logic                w_tick;
  logic [LARG-1:0]     w_iv [N_CANAIS];
  logic [LARG-1:0]     r_cnt [N_CANAIS];
  logic [N_CANAIS-1:0] r_pend;
  logic [N_CANAIS-1:0] r_estouro;
  logic [N_CANAIS-1:0] r_saida;
  estado_t             r_estado;
  logic [PTR_W-1:0]    r_ptr;
  logic [LARG-1:0]     r_on_cnt;
  logic [N_MAX-1:0]    w_pend_ext;
  logic [PTR_W:0]      w_busca;
  logic [PTR_W-1:0]    w_sel;
  logic                w_grant;
  logic [LARG-1:0]     w_tl_sel;
  logic [LARG-1:0]     w_tl_canal;
  logic [LARG:0]       w_on_prox;

  gerador_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .habilita (habilita),
    .tick     (w_tick)
  );

  // Unpack per-channel interval fields
  always_comb begin
    for (int i = 0; i < N_CANAIS; i++) w_iv[i] = intervalo[i*LARG +: LARG];
  end

  assign w_pend_ext = N_MAX'(r_pend);
  assign w_busca    = rr_busca(w_pend_ext, r_ptr, N_CANAIS);
  assign w_sel      = w_busca[PTR_W-1:0];
  assign w_grant    = habilita && (r_estado == OCIOSO) && w_busca[PTR_W];
  assign w_tl_sel   = tempo_ligado[int'(w_sel)*LARG +: LARG];
  // While active, the pointer names the channel that owns the slot
  assign w_tl_canal = tempo_ligado[int'(r_ptr)*LARG +: LARG];
  assign w_on_prox  = {1'b0, r_on_cnt} + 1'b1;

  // Interval counters raise requests, a grant consumes one, overruns stick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CANAIS; i++) r_cnt[i] <= '0;
      r_pend    <= '0;
      r_estouro <= '0;
    end else if (!habilita) begin
      for (int i = 0; i < N_CANAIS; i++) r_cnt[i] <= '0;
      r_pend <= '0;
    end else begin
      for (int i = 0; i < N_CANAIS; i++) begin
        if (w_grant && (int'(w_sel) == i)) r_pend[i] <= 1'b0;
        if (w_iv[i] == '0) begin
          r_cnt[i] <= '0;
        end else if (w_tick) begin
          if (r_cnt[i] == w_iv[i] - LARG'(1)) begin
            r_cnt[i]  <= '0;
            r_pend[i] <= 1'b1;
            if (r_pend[i] || r_saida[i]) r_estouro[i] <= 1'b1;
          end else begin
            r_cnt[i] <= r_cnt[i] + LARG'(1);
          end
        end
      end
    end
  end

  // Scheduler: grant from idle, time the on-period, optional dead-time pause
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= OCIOSO;
      r_ptr    <= PTR_W'(N_CANAIS - 1);
      r_on_cnt <= '0;
      r_saida  <= '0;
    end else if (!habilita) begin
      r_estado <= OCIOSO;
      r_on_cnt <= '0;
      r_saida  <= '0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (w_grant) begin
            r_ptr    <= w_sel;
            r_on_cnt <= '0;
            // A zero on-time consumes the request without touching the load
            if (w_tl_sel != '0) begin
              r_estado <= LIGADO;
              r_saida  <= N_CANAIS'(1) << w_sel;
            end
          end
        end
        LIGADO: begin
          if (w_tick) begin
            // >= so a shortened on-time ends the activation on the next tick
            if (w_on_prox >= {1'b0, w_tl_canal}) begin
              r_saida  <= '0;
              r_on_cnt <= '0;
`ifdef GUARD_TIME_EN
              r_estado <= PAUSA;
`else
              r_estado <= OCIOSO;
`endif
            end else begin
              r_on_cnt <= w_on_prox[LARG-1:0];
            end
          end
        end
`ifdef GUARD_TIME_EN
        PAUSA: begin
          if (w_tick) r_estado <= OCIOSO;
        end
`endif
        default: r_estado <= OCIOSO;
      endcase
    end
  end

  assign saida     = r_saida;
  assign ocupado   = (r_estado != OCIOSO);
  assign pendentes = r_pend;
  assign estouro   = r_estouro;

endmodule

// File: tb/tb_escalonador_timer.sv
// tb/tb_escalonador_timer.sv - directed self-checking bench for escalonador_timer
module tb_escalonador_timer;

`ifdef GUARD_TIME_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        habilita;
  logic [19:0] intervalo;
  logic [19:0] tempo_ligado;
  logic [3:0]  saida;
  logic        ocupado;
  logic [3:0]  pendentes;
  logic [3:0]  estouro;

  int checks;
  int passed;

  logic [3:0] tr_saida [0:63];
  logic [3:0] tr_pend  [0:63];
  logic [3:0] tr_est   [0:63];
  logic       tr_ocup  [0:63];

  escalonador_timer #(.N_CANAIS(4), .LARG(5), .TICK_DIV(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .habilita     (habilita),
    .intervalo    (intervalo),
    .tempo_ligado (tempo_ligado),
    .saida        (saida),
    .ocupado      (ocupado),
    .pendentes    (pendentes),
    .estouro      (estouro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Release reset on a falling edge so the next rising edge is cycle 1
  task automatic apply_reset(input logic [19:0] iv, input logic [19:0] tl);
    @(negedge clk);
    rst_n = 1'b0;
    habilita = 1'b1;
    intervalo = iv;
    tempo_ligado = tl;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // trace index c holds the outputs 1 time unit after rising edge c
  task automatic run(input int from, input int upto);
    for (int c = from; c <= upto; c++) begin
      @(posedge clk);
      #1;
      tr_saida[c] = saida;
      tr_pend[c]  = pendentes;
      tr_est[c]   = estouro;
      tr_ocup[c]  = ocupado;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    checks++; if (saida !== 4'b0000) $display("FAIL reset_saida got=%b exp=0000", saida); else passed++;
    checks++; if (ocupado !== 1'b0) $display("FAIL reset_ocupado got=%b exp=0", ocupado); else passed++;
    checks++; if (pendentes !== 4'b0000) $display("FAIL reset_pend got=%b exp=0000", pendentes); else passed++;
    checks++; if (estouro !== 4'b0000) $display("FAIL reset_estouro got=%b exp=0000", estouro); else passed++;
  endtask

  // ch0 interval 3, on 2: request at tick 3 (edge 13), on edges 14..20, repeats 12 clk later
  task automatic test_single;
    apply_reset({5'd0, 5'd0, 5'd0, 5'd3}, {5'd0, 5'd0, 5'd0, 5'd2});
    run(1, 27);
    checks++; if (tr_pend[12] !== 4'b0000) $display("FAIL t1_pend_c12 got=%b exp=0000", tr_pend[12]); else passed++;
    checks++; if (tr_pend[13] !== 4'b0001) $display("FAIL t1_pend_c13 got=%b exp=0001", tr_pend[13]); else passed++;
    checks++; if (tr_pend[14] !== 4'b0000) $display("FAIL t1_pend_c14 got=%b exp=0000", tr_pend[14]); else passed++;
    checks++; if (tr_saida[13] !== 4'b0000) $display("FAIL t1_saida_c13 got=%b exp=0000", tr_saida[13]); else passed++;
    checks++; if (tr_saida[14] !== 4'b0001) $display("FAIL t1_saida_c14 got=%b exp=0001", tr_saida[14]); else passed++;
    checks++; if (tr_ocup[14] !== 1'b1) $display("FAIL t1_ocup_c14 got=%b exp=1", tr_ocup[14]); else passed++;
    checks++; if (tr_saida[20] !== 4'b0001) $display("FAIL t1_saida_c20 got=%b exp=0001", tr_saida[20]); else passed++;
    checks++; if (tr_saida[21] !== 4'b0000) $display("FAIL t1_saida_c21 got=%b exp=0000", tr_saida[21]); else passed++;
    checks++; if (tr_ocup[21] !== GUARD) $display("FAIL t1_ocup_c21 got=%b exp=%b", tr_ocup[21], GUARD); else passed++;
    checks++; if (tr_saida[25] !== 4'b0000) $display("FAIL t1_saida_c25 got=%b exp=0000", tr_saida[25]); else passed++;
    checks++; if (tr_saida[26] !== 4'b0001) $display("FAIL t1_saida_c26 got=%b exp=0001", tr_saida[26]); else passed++;
    checks++; if (tr_est[27] !== 4'b0000) $display("FAIL t1_estouro got=%b exp=0000", tr_est[27]); else passed++;
  endtask

  // ch0 and ch2 interval 4, on 1: both pending at tick 4, served 0 then 2 each round
  task automatic test_round_robin;
    int bad;
    int e2;
    int e3;
    bad = 0;
    e2 = GUARD ? 26 : 22;
    e3 = GUARD ? 42 : 38;
    apply_reset({5'd0, 5'd4, 5'd0, 5'd4}, {5'd0, 5'd1, 5'd0, 5'd1});
    run(1, 44);
    for (int c = 1; c <= 44; c++) if ($countones(tr_saida[c]) > 1) bad++;
    checks++; if (tr_pend[17] !== 4'b0101) $display("FAIL t2_pend_c17 got=%b exp=0101", tr_pend[17]); else passed++;
    checks++; if (tr_saida[18] !== 4'b0001) $display("FAIL t2_saida_c18 got=%b exp=0001", tr_saida[18]); else passed++;
    checks++; if (tr_pend[18] !== 4'b0100) $display("FAIL t2_pend_c18 got=%b exp=0100", tr_pend[18]); else passed++;
    checks++; if (tr_saida[21] !== 4'b0000) $display("FAIL t2_gap_saida got=%b exp=0000", tr_saida[21]); else passed++;
    checks++; if (tr_ocup[21] !== GUARD) $display("FAIL t2_gap_ocup got=%b exp=%b", tr_ocup[21], GUARD); else passed++;
    checks++; if (tr_saida[e2-1] !== 4'b0000) $display("FAIL t2_ch2_before got=%b exp=0000", tr_saida[e2-1]); else passed++;
    checks++; if (tr_saida[e2] !== 4'b0100) $display("FAIL t2_ch2_first got=%b exp=0100", tr_saida[e2]); else passed++;
    checks++; if (tr_saida[34] !== 4'b0001) $display("FAIL t2_round2_ch0 got=%b exp=0001", tr_saida[34]); else passed++;
    checks++; if (tr_saida[e3] !== 4'b0100) $display("FAIL t2_round2_ch2 got=%b exp=0100", tr_saida[e3]); else passed++;
    checks++; if (bad !== 0) $display("FAIL t2_onehot violations=%0d exp=0", bad); else passed++;
  endtask

  // ch1 interval 2, on 5: re-requests at ticks 4 and 6 while on -> sticky overrun, one queued
  task automatic test_overrun;
    int e;
    e = GUARD ? 34 : 30;
    apply_reset({5'd0, 5'd0, 5'd2, 5'd0}, {5'd0, 5'd0, 5'd5, 5'd0});
    run(1, 40);
    checks++; if (tr_pend[9] !== 4'b0010) $display("FAIL t3_pend_c9 got=%b exp=0010", tr_pend[9]); else passed++;
    checks++; if (tr_saida[10] !== 4'b0010) $display("FAIL t3_saida_c10 got=%b exp=0010", tr_saida[10]); else passed++;
    checks++; if (tr_est[16] !== 4'b0000) $display("FAIL t3_est_c16 got=%b exp=0000", tr_est[16]); else passed++;
    checks++; if (tr_est[17] !== 4'b0010) $display("FAIL t3_est_c17 got=%b exp=0010", tr_est[17]); else passed++;
    checks++; if (tr_pend[17] !== 4'b0010) $display("FAIL t3_pend_c17 got=%b exp=0010", tr_pend[17]); else passed++;
    checks++; if (tr_saida[28] !== 4'b0010) $display("FAIL t3_saida_c28 got=%b exp=0010", tr_saida[28]); else passed++;
    checks++; if (tr_saida[29] !== 4'b0000) $display("FAIL t3_saida_c29 got=%b exp=0000", tr_saida[29]); else passed++;
    checks++; if (tr_saida[e] !== 4'b0010) $display("FAIL t3_requeue_saida got=%b exp=0010", tr_saida[e]); else passed++;
    checks++; if (tr_pend[e] !== 4'b0000) $display("FAIL t3_single_queue got=%b exp=0000", tr_pend[e]); else passed++;
    checks++; if (tr_est[40] !== 4'b0010) $display("FAIL t3_est_sticky got=%b exp=0010", tr_est[40]); else passed++;
  endtask

  // ch3 interval 2, on-time 0: request consumed, load never driven
  task automatic test_zero_on;
    int n_on;
    int n_busy;
    n_on = 0;
    n_busy = 0;
    apply_reset({5'd2, 5'd0, 5'd0, 5'd0}, 20'd0);
    run(1, 24);
    for (int c = 1; c <= 24; c++) begin
      if (tr_saida[c] !== 4'b0000) n_on++;
      if (tr_ocup[c] !== 1'b0) n_busy++;
    end
    checks++; if (tr_pend[9] !== 4'b1000) $display("FAIL t4_pend_c9 got=%b exp=1000", tr_pend[9]); else passed++;
    checks++; if (tr_pend[10] !== 4'b0000) $display("FAIL t4_pend_c10 got=%b exp=0000", tr_pend[10]); else passed++;
    checks++; if (n_on !== 0) $display("FAIL t4_saida_cycles got=%0d exp=0", n_on); else passed++;
    checks++; if (n_busy !== 0) $display("FAIL t4_ocup_cycles got=%0d exp=0", n_busy); else passed++;
    checks++; if (tr_est[24] !== 4'b0000) $display("FAIL t4_estouro got=%b exp=0000", tr_est[24]); else passed++;
  endtask

  // drop habilita while ch0 is on and ch1 queued; re-enable and time the first tick
  task automatic test_habilita;
    apply_reset({5'd0, 5'd0, 5'd5, 5'd5}, {5'd0, 5'd0, 5'd1, 5'd3});
    run(1, 26);
    checks++; if (tr_saida[22] !== 4'b0001) $display("FAIL t5_saida_c22 got=%b exp=0001", tr_saida[22]); else passed++;
    checks++; if (tr_pend[26] !== 4'b0010) $display("FAIL t5_pend_c26 got=%b exp=0010", tr_pend[26]); else passed++;
    habilita = 1'b0;
    run(27, 28);
    checks++; if (tr_saida[27] !== 4'b0000) $display("FAIL t5_off_saida got=%b exp=0000", tr_saida[27]); else passed++;
    checks++; if (tr_ocup[27] !== 1'b0) $display("FAIL t5_off_ocup got=%b exp=0", tr_ocup[27]); else passed++;
    checks++; if (tr_pend[27] !== 4'b0000) $display("FAIL t5_off_pend got=%b exp=0000", tr_pend[27]); else passed++;
    intervalo = {5'd0, 5'd0, 5'd0, 5'd1};
    run(29, 30);
    checks++; if (tr_pend[30] !== 4'b0000) $display("FAIL t5_no_tick_off got=%b exp=0000", tr_pend[30]); else passed++;
    habilita = 1'b1;
    run(31, 36);
    checks++; if (tr_pend[34] !== 4'b0000) $display("FAIL t5_pend_c34 got=%b exp=0000", tr_pend[34]); else passed++;
    checks++; if (tr_pend[35] !== 4'b0001) $display("FAIL t5_pend_c35 got=%b exp=0001", tr_pend[35]); else passed++;
    checks++; if (tr_saida[36] !== 4'b0001) $display("FAIL t5_saida_c36 got=%b exp=0001", tr_saida[36]); else passed++;
  endtask

  // async reset between edges while ch0 is on and ch1 is queued
  task automatic test_async_reset;
    apply_reset({5'd0, 5'd0, 5'd3, 5'd3}, {5'd0, 5'd0, 5'd1, 5'd2});
    run(1, 15);
    checks++; if (tr_pend[13] !== 4'b0011) $display("FAIL t6_pend_c13 got=%b exp=0011", tr_pend[13]); else passed++;
    checks++; if (tr_saida[15] !== 4'b0001) $display("FAIL t6_saida_c15 got=%b exp=0001", tr_saida[15]); else passed++;
    checks++; if (tr_pend[15] !== 4'b0010) $display("FAIL t6_pend_c15 got=%b exp=0010", tr_pend[15]); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (saida !== 4'b0000) $display("FAIL t6_async_saida got=%b exp=0000", saida); else passed++;
    checks++; if (ocupado !== 1'b0) $display("FAIL t6_async_ocup got=%b exp=0", ocupado); else passed++;
    checks++; if (pendentes !== 4'b0000) $display("FAIL t6_async_pend got=%b exp=0000", pendentes); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst_n = 1'b0;
    habilita = 1'b0;
    intervalo = '0;
    tempo_ligado = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_overrun();
    test_zero_on();
    test_habilita();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
